req_latch_4: RTL and testbench

//  Upstream request-capture stage for the 4x2 encoder. Synchronises and debounces 4 raw request

---
 rtl/req_latch_pkg.sv | 53 +++++
 rtl/debounce_1b.sv | 44 ++++
 rtl/req_latch_4.sv | 106 ++++++++++
 tb/tb_req_latch_4.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/req_latch_pkg.sv
// Shared types and grant-selection helpers for the req_latch_4 request-capture stage.
// Optional build macro REQ_ROUND_ROBIN_EN selects rotating priority in req_latch_4.
// Combinational helpers only; no state lives here.
package req_latch_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Fixed priority: bit 3 highest, bit 0 lowest (matches encoder weighting).
  function automatic logic [NREQ-1:0] sel_fixed(input logic [NREQ-1:0] pend);
    logic [NREQ-1:0] g;
    g = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  // Rotating priority: search starts one past the last granted index, wrapping.
  function automatic logic [NREQ-1:0] sel_rr(input logic [NREQ-1:0] pend,
                                             input logic [1:0]      last);
    logic [NREQ-1:0] g;
    logic [1:0]      idx;
    g = '0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = last + 2'd1 + 2'(k);
      if (pend[idx]) begin
        g      = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  // Index of the set bit of a one-hot grant (0 when empty).
  function automatic logic [1:0] onehot_idx(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/debounce_1b.sv
// Single-bit 2-flop synchroniser + counter debouncer, with the debounced level also delayed by one cycle.
// Latency: a held input change appears on level DEB_CYCLES+2 edges after it is first sampled.
// No handshake; free-running every clock.
module debounce_1b
  import req_latch_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic level_d
);

  logic             sync1;
  logic             sync2;
  logic [DEB_W-1:0] cnt;

  // Synchronise, then count consecutive disagreements with the debounced level before toggling it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DEB_W'(DEB_CYCLES)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/req_latch_4.sv
// Debounces 4 raw request lines, latches rising edges as pending, grants one at a time one-hot on y_out.
// Latency: held request -> y_valid DEB_CYCLES+4 edges later; one grant per 2 cycles at most.
// y_out/y_valid held stable until y_ready; REQ_ROUND_ROBIN_EN selects rotating instead of fixed priority.
module req_latch_4
  import req_latch_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_in,
  output logic [3:0] y_out,
  output logic       y_valid,
  input  logic       y_ready,
  output logic [3:0] pending,
  output logic       overflow
);

  logic [3:0] deb;
  logic [3:0] deb_d;
  logic [3:0] rise;
  logic [3:0] clr;
  logic [3:0] grant_q;
  logic [3:0] grant_sel;
  logic       hs;
  state_t     state;
  state_t     state_n;

  for (genvar i = 0; i < NREQ; i++) begin : g_deb
    debounce_1b #(
      .DEB_CYCLES(DEB_CYCLES),
      .DEB_W     (DEB_W)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .din    (req_in[i]),
      .level  (deb[i]),
      .level_d(deb_d[i])
    );
  end

  assign rise = deb & ~deb_d;
  assign hs   = (state == GRANT) & y_ready;
  assign clr  = hs ? grant_q : 4'b0000;

`ifdef REQ_ROUND_ROBIN_EN
  logic [1:0] last_q;

  // Remember the most recently accepted grant so the search rotates past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 2'd3;
    end else if (hs) begin
      last_q <= onehot_idx(grant_q);
    end
  end

  assign grant_sel = sel_rr(pending, last_q);
`else
  assign grant_sel = sel_fixed(pending);
`endif

  // Pending set on rise (wins over same-cycle clear); a rise on a still-pending bit flags overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 4'b0000;
      overflow <= 1'b0;
    end else begin
      pending  <= (pending & ~clr) | rise;
      overflow <= |(rise & pending & ~clr);
    end
  end

  // State register plus the grant latched on entry to GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= 4'b0000;
    end else begin
      state <= state_n;
      if (state == IDLE && pending != 4'b0000) begin
        grant_q <= grant_sel;
      end else if (hs) begin
        grant_q <= 4'b0000;
      end
    end
  end

  // Next state: IDLE grants whenever anything is pending; GRANT waits for the handshake.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pending != 4'b0000) state_n = GRANT;
      GRANT:   if (y_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs: the latched grant is only visible while in GRANT.
  always_comb begin
    y_valid = (state == GRANT);
    y_out   = y_valid ? grant_q : 4'b0000;
  end

endmodule

// File: tb/tb_req_latch_4.sv
// Directed self-checking bench for req_latch_4 (DEB_CYCLES=4).
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Honours REQ_ROUND_ROBIN_EN to pick the matching expectations.
module tb_req_latch_4;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] y_out;
  logic       y_valid;
  logic       y_ready;
  logic [3:0] pending;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  req_latch_4 #(.DEB_CYCLES(4), .DEB_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .y_out   (y_out),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .pending (pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_in  = 4'b0000;
    y_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_first;
`ifdef REQ_ROUND_ROBIN_EN
    exp_first = 4'b0001;
`else
    exp_first = 4'b1000;
`endif
    rst     = 1'b1;
    req_in  = 4'hF;
    y_ready = 1'b0;
    repeat (3) tick();
    checks++; if (y_out !== 4'b0000) begin errors++; $display("FAIL reset_y_out got=%b exp=0000", y_out); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got=%b exp=0", y_valid); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
    repeat (8) tick();
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_early_valid got=%b exp=0", y_valid); end
    tick();
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL reset_lat_valid got=%b exp=1", y_valid); end
    checks++; if (y_out !== exp_first) begin errors++; $display("FAIL reset_first_grant got=%b exp=%b", y_out, exp_first); end
    checks++; if (pending !== 4'hF) begin errors++; $display("FAIL reset_pending_all got=%b exp=1111", pending); end
    // Reset in the middle of a grant drops everything.
    rst    = 1'b1;
    req_in = 4'b0000;
    tick();
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", y_valid); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL midreset_pending got=%b exp=0000", pending); end
    rst = 1'b0;
  endtask

  task automatic test_glitch();
    logic seen;
    do_reset();
    seen   = 1'b0;
    req_in = 4'b0010;
    repeat (3) tick();
    req_in = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (y_valid || pending != 4'b0000) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_rejected got=%b exp=0", seen); end
    req_in = 4'b0010;
    repeat (8) tick();
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL pulse8_early got=%b exp=0", y_valid); end
    req_in = 4'b0000;
    tick();
    checks++; if (y_out !== 4'b0010) begin errors++; $display("FAIL pulse8_grant got=%b exp=0010", y_out); end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL pulse8_valid got=%b exp=1", y_valid); end
  endtask

  task automatic test_priority();
    do_reset();
    req_in = 4'b0101;
    repeat (9) tick();
    checks++; if (y_out !== 4'b0100) begin errors++; $display("FAIL prio_first got=%b exp=0100", y_out); end
    checks++; if (pending !== 4'b0101) begin errors++; $display("FAIL prio_pending got=%b exp=0101", pending); end
    y_ready = 1'b1;
    tick();
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL prio_gap got=%b exp=0", y_valid); end
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL prio_cleared got=%b exp=0001", pending); end
    tick();
    checks++; if (y_out !== 4'b0001) begin errors++; $display("FAIL prio_second got=%b exp=0001", y_out); end
    tick();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL prio_empty got=%b exp=0000", pending); end
    tick();
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL prio_idle got=%b exp=0", y_valid); end
    y_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b0010;
    exp_seq[1] = 4'b0100;
    exp_seq[2] = 4'b1000;
    do_reset();
    req_in = 4'hF;
    repeat (9) tick();
    checks++; if (y_out !== 4'b0001) begin errors++; $display("FAIL rr_first got=%b exp=0001", y_out); end
    y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rr_gap%0d got=%b exp=0", i, y_valid); end
      tick();
      checks++; if (y_out !== exp_seq[i]) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, y_out, exp_seq[i]); end
    end
    tick();
    y_ready = 1'b0;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rr_empty got=%b exp=0000", pending); end
    // Pointer now at 3: bits 0 and 3 pending must grant bit 0 first.
    req_in = 4'b0000;
    repeat (10) tick();
    req_in = 4'b1001;
    repeat (9) tick();
    checks++; if (y_out !== 4'b0001) begin errors++; $display("FAIL rr_wrap got=%b exp=0001", y_out); end
  endtask

  task automatic test_backpressure();
    logic held;
    do_reset();
    req_in = 4'b0001;
    repeat (9) tick();
    checks++; if (y_out !== 4'b0001) begin errors++; $display("FAIL bp_first got=%b exp=0001", y_out); end
    req_in = 4'b1001;
    held   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (y_out !== 4'b0001 || y_valid !== 1'b1) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL bp_stable got=%b exp=1", held); end
    checks++; if (pending !== 4'b1001) begin errors++; $display("FAIL bp_pending got=%b exp=1001", pending); end
    y_ready = 1'b1;
    tick();
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got=%b exp=0", y_valid); end
    tick();
    checks++; if (y_out !== 4'b1000) begin errors++; $display("FAIL bp_next got=%b exp=1000", y_out); end
    tick();
    y_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    req_in = 4'b0100;
    repeat (9) tick();
    checks++; if (y_out !== 4'b0100) begin errors++; $display("FAIL ovf_grant got=%b exp=0100", y_out); end
    req_in = 4'b0000;
    repeat (10) tick();
    req_in = 4'b0100;
    repeat (7) tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got=%b exp=0", overflow); end
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL ovf_pending got=%b exp=0100", pending); end
    // Rise lands on the same edge as the handshake for bit 2.
    req_in = 4'b0000;
    repeat (10) tick();
    req_in = 4'b0100;
    repeat (7) tick();
    y_ready = 1'b1;
    tick();
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL coll_pending got=%b exp=0100", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL coll_overflow got=%b exp=0", overflow); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL coll_accept got=%b exp=0", y_valid); end
    y_ready = 1'b0;
    tick();
    checks++; if (y_out !== 4'b0100) begin errors++; $display("FAIL coll_regrant got=%b exp=0100", y_out); end
  endtask

  initial begin
    rst     = 1'b1;
    req_in  = 4'b0000;
    y_ready = 1'b0;
    test_reset();
    test_glitch();
`ifdef REQ_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_priority();
`endif
    test_backpressure();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
